brtgt_calc: RTL

BRTGT_CALC -- requirements
Module: brtgt_calc

---
 rtl/brtgt_calc_if.sv | 32 +++
 rtl/brtgt_calc.sv | 119 +++++++++++
 2 files changed

// File: rtl/brtgt_calc_if.sv
// rtl/brtgt_calc_if.sv - upstream/downstream handshake bundle for the branch target calculator
interface brtgt_calc_if #(
    parameter int TAG_LEN  = 5,
    parameter int INSN_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [INSN_LEN-1:0] in_inst;
    logic [ADDR_LEN-1:0] in_pc;
    logic [DATA_LEN-1:0] in_brimm;
    logic [DATA_LEN-1:0] in_rs1;
    logic [TAG_LEN-1:0]  in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [ADDR_LEN-1:0] out_target;
    logic [ADDR_LEN-1:0] out_link;
    logic                out_isjmp;
    logic                out_misalign;
    logic [TAG_LEN-1:0]  out_tag;

    modport master (
        output in_valid, in_inst, in_pc, in_brimm, in_rs1, in_tag, out_ready,
        input  in_ready, out_valid, out_target, out_link, out_isjmp, out_misalign, out_tag
    );

    modport slave (
        input  in_valid, in_inst, in_pc, in_brimm, in_rs1, in_tag, out_ready,
        output in_ready, out_valid, out_target, out_link, out_isjmp, out_misalign, out_tag
    );
endinterface

// File: rtl/brtgt_calc.sv
// rtl/brtgt_calc.sv - branch/jump target calculator with a two-entry skid output stage
module brtgt_calc #(
    parameter int TAG_LEN  = 5,
    parameter int INSN_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic          clk,
    input  logic          reset_x,
    input  logic          flush,
    brtgt_calc_if.slave   bus
);
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [ADDR_LEN-1:0] target;
        logic [ADDR_LEN-1:0] link;
        logic                isjmp;
        logic [TAG_LEN-1:0]  tag;
    } entry_t;

    entry_t      m_q, m_d;
    entry_t      s_q, s_d;
    logic [1:0]  count_q, count_d;
    entry_t      new_e;
    logic [ADDR_LEN-1:0] imm_a;
    logic [ADDR_LEN-1:0] jalr_sum;
    logic        acc;
    logic        dlv;
    logic        unused_inst_bits;

    assign unused_inst_bits = ^bus.in_inst[INSN_LEN-1:7];
    assign imm_a    = bus.in_brimm[ADDR_LEN-1:0];
    assign jalr_sum = bus.in_rs1[ADDR_LEN-1:0] + imm_a;

    // Ready depends only on skid occupancy and flush, never on out_ready.
    assign bus.in_ready     = (count_q != 2'd2) && !flush;
    assign bus.out_valid    = (count_q != 2'd0);
    assign bus.out_target   = m_q.target;
    assign bus.out_link     = m_q.link;
    assign bus.out_isjmp    = m_q.isjmp;
    assign bus.out_misalign = m_q.target[1];
    assign bus.out_tag      = m_q.tag;

    assign acc = bus.in_valid && bus.in_ready;
    assign dlv = bus.out_valid && bus.out_ready;

    // Decode the opcode and compute the target/link for the offered item.
    always_comb begin
        new_e        = '0;
        new_e.link   = bus.in_pc + ADDR_LEN'(4);
        new_e.tag    = bus.in_tag;
        case (bus.in_inst[6:0])
            OPC_BRANCH: new_e.target = bus.in_pc + imm_a;
            OPC_JAL: begin
                new_e.target = bus.in_pc + imm_a;
                new_e.isjmp  = 1'b1;
            end
            OPC_JALR: begin
                new_e.target = {jalr_sum[ADDR_LEN-1:1], 1'b0};
                new_e.isjmp  = 1'b1;
            end
            default: begin
                new_e.target = '0;
                new_e.isjmp  = 1'b0;
            end
        endcase
    end

    // Occupancy and M/S steering; flush empties the stage regardless of traffic.
    always_comb begin
        count_d = count_q;
        m_d     = m_q;
        s_d     = s_q;
        case (count_q)
            2'd0: begin
                if (acc) begin
                    m_d     = new_e;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (acc && dlv) begin
                    m_d = new_e;
                end else if (acc) begin
                    s_d     = new_e;
                    count_d = 2'd2;
                end else if (dlv) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (dlv) begin
                    m_d     = s_q;
                    s_d     = '0;
                    count_d = 2'd1;
                end
            end
        endcase
        if (flush) begin
            count_d = 2'd0;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            count_q <= 2'd0;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            count_q <= count_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end
endmodule
